sync_ram_ctrl: RTL
==================

// Module: sync_ram_ctrl
// PURPOSE
//  Request front-end that drives the single-port sync_ram (clk, we, addr, din, dout).
//  Accepts write/read commands on a valid/ready request port and drives the RAM port.
//  Absorbs the RAM's 1-cycle registered read latency and returns read data, in order,
//  on a valid/ready response port with a credit-protected response FIFO.
//  Sits directly upstream of sync_ram; the only agent allowed to drive its port.
// PARAMETERS
//  ADDR_W     4   RAM address width (matches sync_ram: 16 words)
//  DATA_W     8   RAM data width
//  RSP_DEPTH  2   response FIFO entries; legal range >= 2; 2 gives full read throughput
//  CNT_W      16  width of the accepted-read counter
// PORTS
//  clk          in   1        rising-edge clock, shared with sync_ram
//  rst_n        in   1        asynchronous active-low reset
//  req_valid    in   1        request present
//  req_ready    out  1        request accepted at the edge when valid&ready
//  req_we       in   1        1 = write, 0 = read
//  req_addr     in   ADDR_W   word address
//  req_wdata    in   DATA_W   write data (ignored for reads)
//  ram_we       out  1        to sync_ram.we
//  ram_addr     out  ADDR_W   to sync_ram.addr
//  ram_din      out  DATA_W   to sync_ram.din
//  ram_dout     in   DATA_W   from sync_ram.dout, valid the cycle after the read edge
//  rsp_valid    out  1        response beat available (FIFO non-empty)
//  rsp_ready    in   1        consumer takes beat at edge when valid&ready
//  rsp_data     out  DATA_W   read data
//  rsp_addr     out  ADDR_W   address the beat belongs to
//  rsp_is_wr    out  1        1 = write ack beat (only with WR_ACK_EN, else tied 0)
//  rd_cnt       out  CNT_W    accepted reads since reset, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst_n low, async): FIFO empty, pending=0, rd_cnt=0; rsp_valid=0,
//    req_ready=0, ram_we=0 for as long as rst_n is low. In-flight reads are dropped.
//  - RAM port is combinational from the accepted request: ram_we=req_valid&req_ready&req_we;
//    ram_addr=req_addr, ram_din=req_wdata. No RAM access occurs when no request is accepted.
//  - Writes: RAM updates at the accept edge. A read accepted the next cycle to the
//    same address returns the new data.
//  - Reads: accept at edge T sets pending with addr; ram_dout is captured into the FIFO
//    at edge T+1; rsp_valid is high from the cycle after T+1 (2-cycle latency when empty).
//  - Credit: used = occupancy + pending - (rsp_valid&rsp_ready). A read is accepted only
//    when used < RSP_DEPTH. Writes need no credit (unless WR_ACK_EN), so req_ready=1 for
//    writes whenever out of reset.
//  - One request per cycle. Responses are strictly in acceptance order. Push and pop in the
//    same cycle are both allowed, including when the FIFO is full. The FIFO never overflows;
//    an overflow is an assertion failure.
//  - rsp_* holds stable while rsp_valid&!rsp_ready.
//  - rd_cnt increments on each accepted read and holds at 2^CNT_W-1.
// CONFIGURATION
//  SYNC_RAM_CTRL_WR_ACK_EN defined: each accepted write also consumes a credit and pushes
//   a beat {rsp_is_wr=1, rsp_addr, rsp_data=written data} one edge after accept, in order
//   with reads.
//  Undefined: writes produce no beat, rsp_is_wr is tied 0, and writes ignore credit.
// STRUCTURE
//  sync_ram_pkg: ADDR_W/DATA_W defaults; rsp_beat_t struct {is_wr, addr, data}.
//  Sub-module sync_ram_rsp_fifo: RSP_DEPTH-entry FIFO of rsp_beat_t with pointer wrap,
//   count, and push/pop. Top level holds the credit logic, the pending register,
//   rd_cnt, and the RAM drive.
// TESTING
//  1 write 0xA5@2, write 0x3C@5, read 2, read 5, rsp_ready=1 -> beats 0xA5(addr2), 0x3C(addr5).
//  2 back-to-back reads of addr 0..15 with rsp_ready=1 -> one accept per cycle,
//    16 in-order beats, rd_cnt=16.
//  3 rsp_ready=0 then 4 reads -> exactly RSP_DEPTH accepted, req_ready=0 for reads,
//    writes still accepted; release -> remaining reads drain in order.
//  4 write 0x77@9, then read 9 the next cycle -> beat 0x77.
//  5 assert rst_n low while 1 pending and 1 queued read -> rsp_valid=0 immediately;
//    after release, no stale beat is returned.
//  6 WR_ACK_EN: write 0x11@3, then read 3 -> beats {wr,3,0x11} then {rd,3,0x11}.

Source files
------------

// File: rtl/sync_ram_pkg.sv
// Shared widths and response beat type for sync_ram_ctrl.
// Beat layout is identical with or without SYNC_RAM_CTRL_WR_ACK_EN.
package sync_ram_pkg;

    localparam int SRAM_ADDR_W = 4;
    localparam int SRAM_DATA_W = 8;

    typedef struct packed {
        logic                   is_wr;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
    } rsp_beat_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_ram_rsp_fifo.sv
// Response FIFO: DEPTH entries, wrapping pointers and an occupancy count.
// Push and pop may coincide, including when full.
module sync_ram_rsp_fifo
    import sync_ram_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 13,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int            PW   = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] wr_d;
    logic [PW-1:0] rd_q;
    logic [PW-1:0] rd_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wrap_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = wrap_inc(rd_q);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_i && full_o && !pop_i))
                else $error("rsp fifo overflow");
        end
    end

endmodule

// File: rtl/sync_ram_ctrl.sv
// Request front-end for sync_ram with in-order, credit-protected responses.
// SYNC_RAM_CTRL_WR_ACK_EN: writes also take a credit and return an ack beat.
module sync_ram_ctrl
    import sync_ram_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int RSP_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_is_wr,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int CW     = $clog2(RSP_DEPTH + 1);
    localparam int BEAT_W = 1 + ADDR_W + DATA_W;

    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             push_beat;
    beat_t             head_beat;
    logic [BEAT_W-1:0] head_raw;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       used;
    logic              fifo_empty;
    logic              unused_full;
    logic              credit_ok;
    logic              acc;
    logic              acc_rd;
    logic              pop;

    logic              pend_q;
    logic              pend_d;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [ADDR_W-1:0] pend_addr_d;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  rd_cnt_d;

`ifdef SYNC_RAM_CTRL_WR_ACK_EN
    logic              pend_wr_q;
    logic              pend_wr_d;
    logic [DATA_W-1:0] pend_data_q;
    logic [DATA_W-1:0] pend_data_d;
`else
    logic              unused_is_wr;
`endif

    assign pop = rsp_valid & rsp_ready;

    // Outstanding beats, crediting a beat that leaves this cycle.
    always_comb begin
        used      = {1'b0, fifo_cnt};
        used      = used + (CW+1)'(pend_q);
        used      = used - (CW+1)'(pop);
        credit_ok = (used < (CW+1)'(RSP_DEPTH));
    end

`ifdef SYNC_RAM_CTRL_WR_ACK_EN
    assign req_ready = rst_n & credit_ok;
`else
    assign req_ready = rst_n & (req_we | credit_ok);
`endif

    assign acc      = req_valid & req_ready;
    assign acc_rd   = acc & ~req_we;
    assign ram_we   = acc & req_we;
    assign ram_addr = req_addr;
    assign ram_din  = req_wdata;

    always_comb begin
        pend_addr_d = pend_addr_q;
        if (acc) begin
            pend_addr_d = req_addr;
        end
`ifdef SYNC_RAM_CTRL_WR_ACK_EN
        pend_d      = acc;
        pend_wr_d   = pend_wr_q;
        pend_data_d = pend_data_q;
        if (acc) begin
            pend_wr_d   = req_we;
            pend_data_d = req_wdata;
        end
`else
        pend_d = acc_rd;
`endif
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (acc_rd && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.addr = pend_addr_q;
`ifdef SYNC_RAM_CTRL_WR_ACK_EN
        push_beat.is_wr = pend_wr_q;
        push_beat.data  = pend_wr_q ? pend_data_q : ram_dout;
`else
        push_beat.is_wr = 1'b0;
        push_beat.data  = ram_dout;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            rd_cnt_q    <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

`ifdef SYNC_RAM_CTRL_WR_ACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_wr_q   <= 1'b0;
            pend_data_q <= '0;
        end else begin
            pend_wr_q   <= pend_wr_d;
            pend_data_q <= pend_data_d;
        end
    end
`endif

    sync_ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (BEAT_W),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pend_q),
        .din_i   (push_beat),
        .pop_i   (pop),
        .dout_o  (head_raw),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (unused_full)
    );

    assign head_beat = beat_t'(head_raw);
    assign rsp_valid = ~fifo_empty;
    assign rsp_data  = head_beat.data;
    assign rsp_addr  = head_beat.addr;
    assign rd_cnt    = rd_cnt_q;

`ifdef SYNC_RAM_CTRL_WR_ACK_EN
    assign rsp_is_wr = head_beat.is_wr;
`else
    assign rsp_is_wr    = 1'b0;
    assign unused_is_wr = head_beat.is_wr;
`endif

endmodule
